// File: rtl/datamemory_pkg.sv
// rtl/datamemory_pkg.sv - shared constants, state type and lane helper for the data memory
package datamemory_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   function automatic int nlanes(input int width, input int bytewidth);
      return width / bytewidth;
   endfunction

endpackage

// File: rtl/datamemory_lane.sv
// rtl/datamemory_lane.sv - one byte lane of storage with registered read
module datamemory_lane #(
   parameter int ADDRESSWIDTH = 7,
   parameter int DEPTH        = 2**ADDRESSWIDTH,
   parameter int BYTEWIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en_i,
   input  logic [ADDRESSWIDTH-1:0] wr_addr_i,
   input  logic [BYTEWIDTH-1:0]    wr_data_i,
   input  logic                    rd_en_i,
   input  logic [ADDRESSWIDTH-1:0] rd_addr_i,
   output logic [BYTEWIDTH-1:0]    rd_data_o
);

   localparam logic [ADDRESSWIDTH:0] DEPTH_W = (ADDRESSWIDTH+1)'(DEPTH);

   logic [BYTEWIDTH-1:0] mem_q [DEPTH];
   logic [BYTEWIDTH-1:0] rd_data_q;
   logic                 wr_in_range;
   logic                 rd_in_range;

   assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_W);
   assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_W);

   // Storage write; addresses past the end are silently dropped.
   always_ff @(posedge clk) begin
      if (wr_en_i && wr_in_range) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read returning pre-write data; out-of-range reads give zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= rd_in_range ? mem_q[rd_addr_i] : '0;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/datamemory_dp.sv
// rtl/datamemory_dp.sv - simple dual-port data memory with byte enables, clear sequence and RDW control
module datamemory_dp
   import datamemory_pkg::*;
#(
   parameter int ADDRESSWIDTH = 7,
   parameter int DEPTH        = 2**ADDRESSWIDTH,
   parameter int WIDTH        = 32,
   parameter int BYTEWIDTH    = 8,
   parameter int RDW_MODE     = RDW_OLD,
   parameter int OUTREG       = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic                        ready,
   input  logic                        wrEnable,
   input  logic [ADDRESSWIDTH-1:0]     wrAddress,
   input  logic [WIDTH/BYTEWIDTH-1:0]  wrByteEnable,
   input  logic [WIDTH-1:0]            wrData,
   input  logic                        rdEnable,
   input  logic [ADDRESSWIDTH-1:0]     rdAddress,
   output logic [WIDTH-1:0]            rdData,
   output logic                        rdValid
);

   localparam int                      NLANES    = nlanes(WIDTH, BYTEWIDTH);
   localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DEPTH - 1);
   localparam logic [ADDRESSWIDTH:0]   DEPTH_W   = (ADDRESSWIDTH+1)'(DEPTH);

   state_e                   state_q, state_d;
   logic [ADDRESSWIDTH-1:0]  cnt_q, cnt_d;
   logic                     clearing;
   logic                     rd_acc;
   logic                     wr_in_range;
   logic [NLANES-1:0]        lane_we;
   logic [ADDRESSWIDTH-1:0]  lane_addr;
   logic [WIDTH-1:0]         lane_wdata;
   logic [BYTEWIDTH-1:0]     lane_rd [NLANES];
   logic [NLANES-1:0]        fwd_q;
   logic [WIDTH-1:0]         fwd_data_q;
   logic                     v1_q;
   logic [WIDTH-1:0]         stage1_data;

   // State and clear-counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Walk the counter over every word, then hand the ports to the user.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         default: ;
      endcase
   end

   assign ready       = (state_q == ST_RUN);
   assign clearing    = (state_q == ST_CLEAR);
   assign rd_acc      = ready && rdEnable;
   assign wr_in_range = ({1'b0, wrAddress} < DEPTH_W);

   // Write mux: the clear sequence owns the write port until it finishes.
   always_comb begin
      lane_we    = '0;
      lane_addr  = wrAddress;
      lane_wdata = wrData;
      if (clearing) begin
         lane_we    = '1;
         lane_addr  = cnt_q;
         lane_wdata = '0;
      end else if (wrEnable) begin
         lane_we    = wrByteEnable;
      end
   end

   // Capture which lanes a same-address write should override in the read result.
   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_q      <= '0;
         fwd_data_q <= '0;
         v1_q       <= 1'b0;
      end else begin
         v1_q <= rd_acc;
         if (rd_acc) begin
            fwd_data_q <= wrData;
            if (RDW_MODE == RDW_NEW && wrEnable && wr_in_range && wrAddress == rdAddress) begin
               fwd_q <= wrByteEnable;
            end else begin
               fwd_q <= '0;
            end
         end
      end
   end

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      datamemory_lane #(
         .ADDRESSWIDTH (ADDRESSWIDTH),
         .DEPTH        (DEPTH),
         .BYTEWIDTH    (BYTEWIDTH)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .wr_en_i   (lane_we[i]),
         .wr_addr_i (lane_addr),
         .wr_data_i (lane_wdata[i*BYTEWIDTH +: BYTEWIDTH]),
         .rd_en_i   (rd_acc),
         .rd_addr_i (rdAddress),
         .rd_data_o (lane_rd[i])
      );
      assign stage1_data[i*BYTEWIDTH +: BYTEWIDTH] =
         fwd_q[i] ? fwd_data_q[i*BYTEWIDTH +: BYTEWIDTH] : lane_rd[i];
   end

   if (OUTREG != 0) begin : g_outreg
      logic [WIDTH-1:0] out_q;
      logic             v2_q;

      // Extra output stage; advances only when stage one holds a fresh result.
      always_ff @(posedge clk) begin
         if (reset) begin
            out_q <= '0;
            v2_q  <= 1'b0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) begin
               out_q <= stage1_data;
            end
         end
      end

      assign rdData  = out_q;
      assign rdValid = v2_q;
   end else begin : g_direct
      assign rdData  = stage1_data;
      assign rdValid = v1_q;
   end

endmodule
